// File: rtl/blink_pkg.sv
// ============================================================================
// Module   : blink_pkg
// Brief    : Shared state encoding, default widths and register map offsets
//            for the Blink timer core and its register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } blink_state_e;

    localparam int DEF_NUM_LEDS  = 4;
    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_RPT_WIDTH = 16;

    // Byte offsets within the AXI4-Lite slave register block
    localparam logic [7:0] REG_PERIOD_OFS  = 8'h00;
    localparam logic [7:0] REG_ON_TIME_OFS = 8'h04;
    localparam logic [7:0] REG_PATTERN_OFS = 8'h08;
    localparam logic [7:0] REG_CONTROL_OFS = 8'h0C;

endpackage

`default_nettype wire

// File: rtl/blink_timer_core_if.sv
// ============================================================================
// Module   : blink_timer_core_if
// Brief    : Control/configuration strobes and status outputs of the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface blink_timer_core_if
    import blink_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int RPT_WIDTH = DEF_RPT_WIDTH
) ();

    logic                 start;
    logic                 stop;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [CNT_WIDTH-1:0] cfg_on_time;
    logic [NUM_LEDS-1:0]  cfg_pattern;
    logic                 cfg_chase;
    logic [RPT_WIDTH-1:0] cfg_repeat;
    logic                 cfg_irq_every;
    logic [NUM_LEDS-1:0]  led;
    logic                 busy;
    logic                 intr_pulse;
    logic                 err_pulse;
    logic [RPT_WIDTH-1:0] periods_done;

    modport master (
        output start, stop, cfg_period, cfg_on_time, cfg_pattern,
               cfg_chase, cfg_repeat, cfg_irq_every,
        input  led, busy, intr_pulse, err_pulse, periods_done
    );

    modport slave (
        input  start, stop, cfg_period, cfg_on_time, cfg_pattern,
               cfg_chase, cfg_repeat, cfg_irq_every,
        output led, busy, intr_pulse, err_pulse, periods_done
    );

endinterface

`default_nettype wire

// File: rtl/blink_pattern_shifter.sv
// ============================================================================
// Module   : blink_pattern_shifter
// Brief    : Holds the current LED pattern; load, rotate-left and on-phase gate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blink_pattern_shifter #(
    parameter int NUM_LEDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_rotate,
    input  logic                i_on,
    input  logic [NUM_LEDS-1:0] i_pattern,
    output logic [NUM_LEDS-1:0] o_led
);

    logic [NUM_LEDS-1:0] r_pattern;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_pattern_nxt;

    // Shift-or form of the rotate also holds for a single LED
    always_comb begin
        w_pattern_nxt = r_pattern;
        if (i_load) begin
            w_pattern_nxt = i_pattern;
        end else if (i_rotate) begin
            w_pattern_nxt = (r_pattern << 1) | (r_pattern >> (NUM_LEDS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
            r_led     <= '0;
        end else begin
            r_pattern <= w_pattern_nxt;
            r_led     <= i_on ? w_pattern_nxt : '0;
        end
    end

    assign o_led = r_led;

endmodule

`default_nettype wire

// File: rtl/blink_timer_core.sv
// ============================================================================
// Module   : blink_timer_core
// Brief    : Period/on-time counter and IDLE/RUN control for LED blinking,
//            with completion/period interrupt and rejected-start pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blink_timer_core
    import blink_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int RPT_WIDTH = DEF_RPT_WIDTH
) (
    input  logic              ACLK,
    input  logic              ARESET,
    blink_timer_core_if.slave io_bus
);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_RUN  = ST_RUN;

    logic [0:0]           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_period, r_on_time, w_on_nxt, w_on_clamp;
    logic [RPT_WIDTH-1:0] r_repeat, r_periods_done, w_pd_nxt, w_pd_inc;
    logic                 r_chase, r_irq_every, r_intr, r_err;
    logic                 w_start, w_load, w_period_end, w_done, w_rotate, w_led_on;

    // Priority: stop, then start, then period end; the LED gate uses next-state values
    always_comb begin
        w_start      = io_bus.start && !io_bus.stop;
        w_load       = w_start && (io_bus.cfg_period != '0);
        w_on_clamp   = (io_bus.cfg_on_time > io_bus.cfg_period) ? io_bus.cfg_period
                                                                : io_bus.cfg_on_time;
        w_period_end = (r_state == S_RUN) && (r_cnt == r_period - CNT_WIDTH'(1));
        w_pd_inc     = (&r_periods_done) ? r_periods_done
                                         : r_periods_done + RPT_WIDTH'(1);
        w_done       = w_period_end && (r_repeat != '0) && (w_pd_inc == r_repeat);
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pd_nxt     = r_periods_done;
        w_on_nxt     = r_on_time;
        w_rotate     = 1'b0;
        if (io_bus.stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (io_bus.start) begin
            w_cnt_nxt = '0;
            if (w_load) begin
                w_state_nxt = S_RUN;
                w_pd_nxt    = '0;
                w_on_nxt    = w_on_clamp;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (w_period_end) begin
            w_cnt_nxt = '0;
            w_pd_nxt  = w_pd_inc;
            w_rotate  = r_chase;
            if (w_done) begin
                w_state_nxt = S_IDLE;
            end
        end else if (r_state == S_RUN) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
        w_led_on = (w_state_nxt == S_RUN) && (w_cnt_nxt < w_on_nxt);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_periods_done <= '0;
            r_on_time      <= '0;
            r_period       <= '0;
            r_repeat       <= '0;
            r_chase        <= 1'b0;
            r_irq_every    <= 1'b0;
            r_intr         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_periods_done <= w_pd_nxt;
            r_on_time      <= w_on_nxt;
            r_intr         <= !io_bus.stop && !io_bus.start && w_period_end
                              && (r_irq_every || w_done);
            r_err          <= w_start && !w_load;
            if (w_load) begin
                r_period    <= io_bus.cfg_period;
                r_repeat    <= io_bus.cfg_repeat;
                r_chase     <= io_bus.cfg_chase;
                r_irq_every <= io_bus.cfg_irq_every;
            end
        end
    end

    blink_pattern_shifter #(
        .NUM_LEDS (NUM_LEDS)
    ) u_shifter (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_load    (w_load),
        .i_rotate  (w_rotate),
        .i_on      (w_led_on),
        .i_pattern (io_bus.cfg_pattern),
        .o_led     (io_bus.led)
    );

    assign io_bus.busy         = (r_state == S_RUN);
    assign io_bus.intr_pulse   = r_intr;
    assign io_bus.err_pulse    = r_err;
    assign io_bus.periods_done = r_periods_done;

endmodule

`default_nettype wire

// File: tb/tb_blink_timer_core.sv
// ============================================================================
// Module   : tb_blink_timer_core
// Brief    : Self-checking bench; expectations come from a closed-form model
//            indexed by cycles elapsed since the last accepted start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_blink_timer_core;
    import blink_pkg::*;

    localparam int NL = 4;
    localparam int CW = 32;
    localparam int RW = 16;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    blink_timer_core_if #(.NUM_LEDS(NL), .CNT_WIDTH(CW), .RPT_WIDTH(RW)) io ();

    blink_timer_core #(.NUM_LEDS(NL), .CNT_WIDTH(CW), .RPT_WIDTH(RW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .io_bus (io)
    );

    int total = 0;
    int bad   = 0;

    int       m_P, m_T, m_N;
    logic [3:0] m_pat;
    bit       m_chase, m_irq;

    function automatic bit m_busy(input int j);
        return (m_N == 0) || (j < m_N * m_P);
    endfunction

    function automatic logic [3:0] m_led(input int j);
        int         tp;
        logic [7:0] t;
        tp = (m_T < m_P) ? m_T : m_P;
        if (!m_busy(j) || (j % m_P) >= tp) return 4'b0000;
        t = {m_pat, m_pat} << (m_chase ? (j / m_P) % 4 : 0);
        return t[7:4];
    endfunction

    function automatic bit m_intr(input int j);
        if (j == 0 || (j % m_P) != 0) return 1'b0;
        if (m_N != 0 && j > m_N * m_P) return 1'b0;
        return m_irq || (m_N != 0 && j == m_N * m_P);
    endfunction

    function automatic int m_pd(input int j);
        int p;
        p = j / m_P;
        if (m_N != 0 && p > m_N) p = m_N;
        return p;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // After return, the DUT state reflects the edge that sampled start (j = 0)
    task automatic do_start(input int P, input int T, input logic [3:0] pat,
                            input bit ch, input int N, input bit irq);
        io.start = 1'b1;        io.cfg_period = CW'(P); io.cfg_on_time = CW'(T);
        io.cfg_pattern = pat;   io.cfg_chase = ch;      io.cfg_repeat = RW'(N);
        io.cfg_irq_every = irq;
        m_P = P; m_T = T; m_pat = pat; m_chase = ch; m_N = N; m_irq = irq;
        tick();
        io.start = 1'b0;
        io.cfg_period    = CW'($urandom_range(1, 20));
        io.cfg_on_time   = CW'($urandom_range(0, 20));
        io.cfg_pattern   = 4'($urandom);
        io.cfg_chase     = 1'($urandom);
        io.cfg_repeat    = RW'($urandom_range(0, 5));
        io.cfg_irq_every = 1'($urandom);
    endtask

    task automatic test_reset();
        ARESET = 1'b1; io.start = 1'b0; io.stop = 1'b0;
        io.cfg_period = '0; io.cfg_on_time = '0; io.cfg_pattern = '0;
        io.cfg_chase = 1'b0; io.cfg_repeat = '0; io.cfg_irq_every = 1'b0;
        tick(); tick();
        ARESET = 1'b0;
        total++; if (io.led !== 4'b0)   begin bad++; $display("FAIL reset led got=%b exp=0000", io.led); end
        total++; if (io.busy !== 1'b0)  begin bad++; $display("FAIL reset busy got=%b exp=0", io.busy); end
        total++; if (io.intr_pulse !== 1'b0) begin bad++; $display("FAIL reset intr got=%b exp=0", io.intr_pulse); end
        total++; if (io.err_pulse !== 1'b0)  begin bad++; $display("FAIL reset err got=%b exp=0", io.err_pulse); end
        total++; if (io.periods_done !== 16'd0) begin bad++; $display("FAIL reset pd got=%0d exp=0", io.periods_done); end
        do_start(10, 5, 4'b1111, 1'b0, 0, 1'b1);
        repeat (6) tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        total++; if (io.led !== 4'b0)   begin bad++; $display("FAIL midreset led got=%b exp=0000", io.led); end
        total++; if (io.busy !== 1'b0)  begin bad++; $display("FAIL midreset busy got=%b exp=0", io.busy); end
        total++; if (io.intr_pulse !== 1'b0) begin bad++; $display("FAIL midreset intr got=%b exp=0", io.intr_pulse); end
        total++; if (io.periods_done !== 16'd0) begin bad++; $display("FAIL midreset pd got=%0d exp=0", io.periods_done); end
    endtask

    task automatic test_basic_blink();
        do_start(10, 4, 4'b0101, 1'b0, 3, 1'b0);
        for (int j = 0; j < 36; j++) begin
            total++; if (io.led !== m_led(j)) begin bad++; $display("FAIL basic led j=%0d got=%b exp=%b", j, io.led, m_led(j)); end
            total++; if (io.busy !== m_busy(j)) begin bad++; $display("FAIL basic busy j=%0d got=%b exp=%b", j, io.busy, m_busy(j)); end
            total++; if (io.intr_pulse !== m_intr(j)) begin bad++; $display("FAIL basic intr j=%0d got=%b exp=%b", j, io.intr_pulse, m_intr(j)); end
            total++; if (io.periods_done !== RW'(m_pd(j))) begin bad++; $display("FAIL basic pd j=%0d got=%0d exp=%0d", j, io.periods_done, m_pd(j)); end
            tick();
        end
    endtask

    task automatic test_chase_irq();
        do_start(4, 4, 4'b0001, 1'b1, 0, 1'b1);
        for (int j = 0; j < 22; j++) begin
            total++; if (io.led !== m_led(j)) begin bad++; $display("FAIL chase led j=%0d got=%b exp=%b", j, io.led, m_led(j)); end
            total++; if (io.intr_pulse !== m_intr(j)) begin bad++; $display("FAIL chase intr j=%0d got=%b exp=%b", j, io.intr_pulse, m_intr(j)); end
            total++; if (io.periods_done !== RW'(m_pd(j))) begin bad++; $display("FAIL chase pd j=%0d got=%0d exp=%0d", j, io.periods_done, m_pd(j)); end
            tick();
        end
        // j = 22 is mid-period; stop lands there
        io.stop = 1'b1; tick(); io.stop = 1'b0;
        total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL chase_stop busy got=%b exp=0", io.busy); end
        total++; if (io.led !== 4'b0)  begin bad++; $display("FAIL chase_stop led got=%b exp=0000", io.led); end
        total++; if (io.periods_done !== RW'(m_pd(22))) begin bad++; $display("FAIL chase_stop pd got=%0d exp=%0d", io.periods_done, m_pd(22)); end
    endtask

    task automatic test_stop_collision();
        do_start(int'($urandom_range(6, 10)), int'($urandom_range(3, 12)), 4'b1011, 1'b0, 0, 1'b1);
        repeat (3) tick();
        io.stop = 1'b1; tick(); io.stop = 1'b0;
        total++; if (io.led !== 4'b0)  begin bad++; $display("FAIL stop led got=%b exp=0000", io.led); end
        total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL stop busy got=%b exp=0", io.busy); end
        total++; if (io.intr_pulse !== 1'b0) begin bad++; $display("FAIL stop intr got=%b exp=0", io.intr_pulse); end
        io.start = 1'b1; io.stop = 1'b1; io.cfg_period = 32'd0;
        tick();
        io.start = 1'b0; io.stop = 1'b0;
        total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL collide busy got=%b exp=0", io.busy); end
        total++; if (io.err_pulse !== 1'b0) begin bad++; $display("FAIL collide err got=%b exp=0", io.err_pulse); end
        total++; if (io.led !== 4'b0)  begin bad++; $display("FAIL collide led got=%b exp=0000", io.led); end
    endtask

    task automatic test_invalid_clamp();
        io.start = 1'b1; io.cfg_period = 32'd0; io.cfg_on_time = 32'd3; io.cfg_pattern = 4'hF;
        tick();
        io.start = 1'b0;
        total++; if (io.err_pulse !== 1'b1) begin bad++; $display("FAIL p0 err got=%b exp=1", io.err_pulse); end
        total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL p0 busy got=%b exp=0", io.busy); end
        tick();
        total++; if (io.err_pulse !== 1'b0) begin bad++; $display("FAIL p0 err_clear got=%b exp=0", io.err_pulse); end
        do_start(5, 9, 4'($urandom_range(1, 15)), 1'b0, 2, 1'b0);
        for (int j = 0; j < 12; j++) begin
            total++; if (io.led !== m_led(j)) begin bad++; $display("FAIL clamp led j=%0d got=%b exp=%b", j, io.led, m_led(j)); end
            total++; if (io.busy !== m_busy(j)) begin bad++; $display("FAIL clamp busy j=%0d got=%b exp=%b", j, io.busy, m_busy(j)); end
            tick();
        end
        do_start(5, 2, 4'b0110, 1'b0, 0, 1'b0);
        repeat (2) tick();
        io.start = 1'b1; io.cfg_period = 32'd0;
        tick();
        io.start = 1'b0;
        total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL p0run busy got=%b exp=0", io.busy); end
        total++; if (io.err_pulse !== 1'b1) begin bad++; $display("FAIL p0run err got=%b exp=1", io.err_pulse); end
        total++; if (io.led !== 4'b0)  begin bad++; $display("FAIL p0run led got=%b exp=0000", io.led); end
    endtask

    task automatic test_restart();
        do_start(8, 4, 4'b1100, 1'b0, 2, 1'b0);
        repeat (5) tick();
        do_start(3, 1, 4'b0011, 1'b0, 1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            total++; if (io.intr_pulse !== m_intr(j)) begin bad++; $display("FAIL restart intr j=%0d got=%b exp=%b", j, io.intr_pulse, m_intr(j)); end
            total++; if (io.periods_done !== RW'(m_pd(j))) begin bad++; $display("FAIL restart pd j=%0d got=%0d exp=%0d", j, io.periods_done, m_pd(j)); end
            total++; if (io.busy !== m_busy(j)) begin bad++; $display("FAIL restart busy j=%0d got=%b exp=%b", j, io.busy, m_busy(j)); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int ncyc;
            do_start(int'($urandom_range(1, 9)), int'($urandom_range(0, 11)), 4'($urandom),
                     1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            ncyc = (m_N != 0) ? m_N * m_P + 3 : 25;
            for (int j = 0; j < ncyc; j++) begin
                total++; if (io.led !== m_led(j)) begin bad++; $display("FAIL rand%0d led j=%0d got=%b exp=%b", k, j, io.led, m_led(j)); end
                total++; if (io.busy !== m_busy(j)) begin bad++; $display("FAIL rand%0d busy j=%0d got=%b exp=%b", k, j, io.busy, m_busy(j)); end
                total++; if (io.intr_pulse !== m_intr(j)) begin bad++; $display("FAIL rand%0d intr j=%0d got=%b exp=%b", k, j, io.intr_pulse, m_intr(j)); end
                total++; if (io.periods_done !== RW'(m_pd(j))) begin bad++; $display("FAIL rand%0d pd j=%0d got=%0d exp=%0d", k, j, io.periods_done, m_pd(j)); end
                total++; if (io.err_pulse !== 1'b0) begin bad++; $display("FAIL rand%0d err j=%0d got=%b exp=0", k, j, io.err_pulse); end
                tick();
            end
            io.stop = 1'b1; tick(); io.stop = 1'b0;
            total++; if (io.busy !== 1'b0 || io.led !== 4'b0 || io.intr_pulse !== 1'b0)
                begin bad++; $display("FAIL rand%0d stop busy=%b led=%b intr=%b exp=0/0000/0", k, io.busy, io.led, io.intr_pulse); end
            total++; if (io.periods_done !== RW'(m_pd(ncyc))) begin bad++; $display("FAIL rand%0d stop_pd got=%0d exp=%0d", k, io.periods_done, m_pd(ncyc)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_blink();
        test_chase_irq();
        test_stop_collision();
        test_invalid_clamp();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/blink_timer_core.md
Name: blink_timer_core

Overview:
- User-logic stage directly downstream of the Blink AXI4-Lite register file.
- Consumes the start/stop strobes and configuration fields decoded from the slave registers.
- Generates timed LED blink patterns and a one-cycle interrupt-source pulse.
- That pulse feeds bit 0 of the interrupt controller, which produces irq.

Parameters:
- NUM_LEDS, 4, width of LED output and pattern field.
- CNT_WIDTH, 32, width of the period and on-time counters.
- RPT_WIDTH, 16, width of the repeat-count field and the completed-period counter.

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- start  in  1  one-cycle strobe from the control-register write; latches configuration and begins blinking.
- stop  in  1  one-cycle strobe; aborts blinking.
- cfg_period  in  CNT_WIDTH  period P in ACLK cycles.
- cfg_on_time  in  CNT_WIDTH  on-time T in ACLK cycles.
- cfg_pattern  in  NUM_LEDS  initial LED pattern.
- cfg_chase  in  1  0 = blink whole pattern; 1 = rotate pattern left each period.
- cfg_repeat  in  RPT_WIDTH  number of periods N; 0 = run forever.
- cfg_irq_every  in  1  1 = interrupt each period end; 0 = interrupt only on completion.
- led  out  NUM_LEDS  LED drive.
- busy  out  1  high while running.
- intr_pulse  out  1  one-cycle interrupt source to the interrupt controller.
- err_pulse  out  1  one-cycle flag for a rejected start.
- periods_done  out  RPT_WIDTH  count of completed periods since the last start (readable status).

Behaviour:
- Reset (ARESET=1 at an edge):
  - state=IDLE.
  - led=0, busy=0, intr_pulse=0, err_pulse=0, periods_done=0, phase counter cnt=0.
  - Reset mid-run aborts immediately; no pulse is issued.
- States:
  - IDLE: led=0, busy=0.
  - RUN: busy=1.
- Start (in IDLE or RUN):
  - start with cfg_period==0: stays or returns to IDLE, err_pulse=1 next cycle, led=0.
  - Otherwise: latch P, T'=min(T,P), pattern, chase, N, irq_every into shadow registers; cnt=0; periods_done=0; state=RUN.
  - start during RUN restarts with the new configuration.
  - Later changes on cfg_* have no effect until the next start.
- Output timing: all outputs are registered.
  - start sampled at edge k: busy=1 at k+1, and led=pattern if T'>0.
- RUN, each cycle:
  - led = cur_pattern when cnt < T', else 0.
  - T'==P gives always on; T'==0 gives always off.
  - cnt increments.
- Period end (cnt==P-1):
  - cnt wraps to 0.
  - periods_done increments, saturating at all-ones.
  - If chase=1, cur_pattern rotates left by 1 (MSB wraps to bit 0).
  - intr_pulse=1 for the following cycle if irq_every=1.
- Completion:
  - When N!=0 and the period end makes periods_done==N: intr_pulse=1 (exactly one pulse, even if irq_every=1), state=IDLE, led=0, busy=0, all on the same next cycle.
  - periods_done holds its value until the next start.
- P=1 edge case: every cycle is a period end; with irq_every=1, intr_pulse stays high continuously (one pulse per cycle).
- stop in RUN: state=IDLE next cycle, led=0, no intr_pulse; periods_done holds.
- Simultaneous events:
  - stop in IDLE: no effect.
  - start and stop in the same cycle: stop wins, start is ignored, no err_pulse.
  - stop coinciding with a completion period end: stop wins, no intr_pulse.
- Width rules:
  - Comparisons are unsigned.
  - cnt is CNT_WIDTH bits; P up to 2^CNT_WIDTH-1 is supported.

Decomposition:
- Shared package blink_pkg holds:
  - state enum {IDLE, RUN};
  - default parameter constants;
  - register offsets for period/on-time/pattern/control, so the register file and this core agree.
- One natural sub-module: blink_pattern_shifter, which holds cur_pattern and implements load/rotate/gate-by-on-phase.
- Counter and FSM stay in the top level.

Test Plan:
- Reset mid-run: start P=10 T=5, assert ARESET at cycle 7 -> next cycle led=0, busy=0, periods_done=0, no intr_pulse.
- Basic blink: start P=10 T=4 pattern=4'b0101 N=3 irq_every=0 -> led=4'b0101 for 4 cycles then 0 for 6, three times; single intr_pulse 30 cycles after busy rises; busy then 0; periods_done=3.
- Chase with per-period IRQ: P=4 T=4 pattern=4'b0001 chase=1 N=0 irq_every=1 -> led 0001,0010,0100,1000,0001, each held 4 cycles; intr_pulse every 4 cycles; runs until stop.
- Stop and start/stop collision: stop mid-period -> led=0 next cycle, no pulse; start+stop in the same cycle from IDLE -> stays IDLE, busy=0, err_pulse=0.
- Invalid/clamp: start with P=0 -> err_pulse=1 for one cycle, busy=0; start P=5 T=9 -> led constantly pattern while busy.
- Restart: start P=8 N=2, restart at cycle 5 with P=3 N=1 -> periods_done=0 then 1; intr_pulse 3 cycles after restart; no pulse from the first configuration.
